hack_memory_map: RTL and testbench

HACK_MEMORY_MAP -- requirements
Module: hack_memory_map

---
 rtl/hack_pkg.sv | 45 ++++
 rtl/hack_kbd_fifo.sv | 66 ++++++
 rtl/hack_memory_map.sv | 175 +++++++++++++++++
 tb/tb_hack_memory_map.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory map: address regions, controller
// states, default map constants and the region decoder.
package hack_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    typedef enum logic {
        ST_IDLE,
        ST_SCR_WAIT
    } mm_state_e;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_RAM_AW    = 14;
    localparam int DEF_SCR_BASE  = 16384;
    localparam int DEF_SCR_AW    = 13;
    localparam int DEF_KBD_ADDR  = 24576;
    localparam int DEF_KBD_DEPTH = 4;

    // RAM wins over the other regions if the parameters ever make them overlap.
    function automatic region_e decode_region(input logic [31:0] a, input int ram_aw,
                                              input int scr_base, input int scr_aw,
                                              input int kbd_addr);
        logic [31:0] ram_top;
        logic [31:0] scr_lo;
        logic [31:0] scr_hi;
        ram_top = 32'(1) << ram_aw;
        scr_lo  = 32'(scr_base);
        scr_hi  = scr_lo + (32'(1) << scr_aw);
        if (a < ram_top) begin
            return REG_RAM;
        end else if (a >= scr_lo && a < scr_hi) begin
            return REG_SCR;
        end else if (a == 32'(kbd_addr)) begin
            return REG_KBD;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_kbd_fifo.sv
// Scancode FIFO: drops pushes when full (sticky overflow), shows head without
// popping, and lets a pop make room for a push in the same cycle.
module hack_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] code,
    input  logic       pop,
    output logic [7:0] head,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    store_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pop) ovf_d = 1'b0;
        if (push && full && !do_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= code;
    end

    assign head     = empty ? 8'h00 : store_q[rd_ptr_q];
    assign overflow = ovf_q;

endmodule

// File: rtl/hack_memory_map.sv
// Hack CPU memory map: on-chip RAM, external screen memory with an ack
// handshake, and a memory-mapped keyboard scancode FIFO.
module hack_memory_map
    import hack_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAM_AW    = DEF_RAM_AW,
    parameter int SCR_BASE  = DEF_SCR_BASE,
    parameter int SCR_AW    = DEF_SCR_AW,
    parameter int KBD_ADDR  = DEF_KBD_ADDR,
    parameter int KBD_DEPTH = DEF_KBD_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              scr_req,
    output logic              scr_we,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_wdata,
    input  logic              scr_ack,
    input  logic [DATA_W-1:0] scr_rdata,
    input  logic [7:0]        kbd_code,
    input  logic              kbd_strobe,
    output logic              kbd_overflow,
    output mm_state_e         dbg_state
);
    // Handshake: a CPU access is taken on any posedge where req && ready; reads
    // answer with a one-cycle rvalid. The screen side holds scr_req and its
    // payload steady until the posedge where scr_ack is seen high.
    region_e           region;
    logic              accept;
    logic              kbd_pop;
    logic [7:0]        kbd_head;
    logic [DATA_W-1:0] mem [2**RAM_AW];
    logic [DATA_W-1:0] ram_rd_q;

    mm_state_e         state_q, state_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_ram_q, rd_ram_d;
    logic              scr_req_q, scr_req_d;
    logic              scr_we_q, scr_we_d;
    logic [SCR_AW-1:0] scr_addr_q, scr_addr_d;
    logic [DATA_W-1:0] scr_wdata_q, scr_wdata_d;

    assign region = decode_region(32'(addr), RAM_AW, SCR_BASE, SCR_AW, KBD_ADDR);
    assign accept = req && ready_q;

    always_ff @(posedge clk) begin
        if (accept && region == REG_RAM) begin
            if (we) mem[addr[RAM_AW-1:0]] <= wdata;
            else    ram_rd_q <= mem[addr[RAM_AW-1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        rd_ram_d    = rd_ram_q;
        scr_req_d   = scr_req_q;
        scr_we_d    = scr_we_q;
        scr_addr_d  = scr_addr_q;
        scr_wdata_d = scr_wdata_q;
        kbd_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (region)
                        REG_RAM: begin
                            if (!we) begin
                                rvalid_d = 1'b1;
                                rd_ram_d = 1'b1;
                            end
                        end
                        REG_SCR: begin
                            state_d     = ST_SCR_WAIT;
                            ready_d     = 1'b0;
                            scr_req_d   = 1'b1;
                            scr_we_d    = we;
                            scr_addr_d  = SCR_AW'(addr - ADDR_W'(SCR_BASE));
                            scr_wdata_d = wdata;
                        end
                        REG_KBD: begin
                            if (we) begin
                                kbd_pop = 1'b1;
                            end else begin
                                rvalid_d = 1'b1;
                                rd_ram_d = 1'b0;
                                rdata_d  = DATA_W'(kbd_head);
                            end
                        end
                        default: begin
                            if (!we) begin
                                rvalid_d = 1'b1;
                                rd_ram_d = 1'b0;
                                rdata_d  = '0;
                            end
                        end
                    endcase
                end
            end
            ST_SCR_WAIT: begin
                if (scr_ack) begin
                    state_d   = ST_IDLE;
                    ready_d   = 1'b1;
                    scr_req_d = 1'b0;
                    scr_we_d  = 1'b0;
                    if (!scr_we_q) begin
                        rvalid_d = 1'b1;
                        rd_ram_d = 1'b0;
                        rdata_d  = scr_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rd_ram_q    <= 1'b0;
            scr_req_q   <= 1'b0;
            scr_we_q    <= 1'b0;
            scr_addr_q  <= '0;
            scr_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rd_ram_q    <= rd_ram_d;
            scr_req_q   <= scr_req_d;
            scr_we_q    <= scr_we_d;
            scr_addr_q  <= scr_addr_d;
            scr_wdata_q <= scr_wdata_d;
        end
    end

    hack_kbd_fifo #(
        .DEPTH(KBD_DEPTH)
    ) u_kbd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (kbd_strobe),
        .code    (kbd_code),
        .pop     (kbd_pop),
        .head    (kbd_head),
        .overflow(kbd_overflow)
    );

    // RAM reads come straight from the synchronous array output.
    assign rdata     = rd_ram_q ? ram_rd_q : rdata_q;
    assign ready     = ready_q;
    assign rvalid    = rvalid_q;
    assign scr_req   = scr_req_q;
    assign scr_we    = scr_we_q;
    assign scr_addr  = scr_addr_q;
    assign scr_wdata = scr_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hack_memory_map.sv
// Directed bench for hack_memory_map: RAM, screen handshake, keyboard FIFO,
// unmapped space and reset during a screen access.
module tb_hack_memory_map;
    import hack_pkg::*;

    localparam logic [14:0] KBD = 15'd24576;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        scr_req, scr_we;
    logic [12:0] scr_addr;
    logic [15:0] scr_wdata;
    logic        scr_ack;
    logic [15:0] scr_rdata;
    logic [7:0]  kbd_code;
    logic        kbd_strobe;
    logic        kbd_overflow;
    mm_state_e   dbg_state;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rv_count = 0;
    int          rv_snap;
    logic [15:0] exp_q[$];

    hack_memory_map dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .scr_req(scr_req), .scr_we(scr_we), .scr_addr(scr_addr), .scr_wdata(scr_wdata),
        .scr_ack(scr_ack), .scr_rdata(scr_rdata),
        .kbd_code(kbd_code), .kbd_strobe(kbd_strobe), .kbd_overflow(kbd_overflow),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rvalid === 1'b1) rv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check("wr_ready", ready, 1);
        check("wr_no_rvalid", rvalid, 0);
    endtask

    task automatic cpu_read(input logic [14:0] a, input logic [15:0] e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        check("rd_rvalid", rvalid, 1);
        check("rd_data", rdata, exp_q.pop_front());
        @(posedge clk); #1;
        check("rd_rvalid_pulse", rvalid, 0);
    endtask

    task automatic kbd_push(input logic [7:0] c);
        @(posedge clk); #1;
        kbd_code = c; kbd_strobe = 1'b1;
        @(posedge clk); #1;
        kbd_strobe = 1'b0;
    endtask

    task automatic kbd_push_pop(input logic [7:0] c);
        @(posedge clk); #1;
        kbd_code = c; kbd_strobe = 1'b1;
        req = 1'b1; we = 1'b1; addr = KBD; wdata = 16'hFFFF;
        @(posedge clk); #1;
        kbd_strobe = 1'b0; req = 1'b0; we = 1'b0;
    endtask

    // lat = cycles scr_req stays high; poke drives a RAM write into the busy window
    task automatic scr_access(input logic w, input logic [14:0] a, input logic [15:0] wd,
                              input int lat, input logic [15:0] rd, input logic [12:0] exp_sa,
                              input logic poke);
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        if (poke) begin
            req = 1'b1; we = 1'b1; addr = 15'd7; wdata = 16'hDEAD;
        end
        for (int i = 0; i < lat; i++) begin
            if (i == 1) begin
                req = 1'b0; we = 1'b0;
            end
            check("scr_req_high", scr_req, 1);
            check("scr_ready_low", ready, 0);
            check("scr_state", 32'(dbg_state), 32'(ST_SCR_WAIT));
            check("scr_addr", scr_addr, exp_sa);
            check("scr_we", scr_we, w);
            if (w) check("scr_wdata", scr_wdata, wd);
            if (i == lat - 1) begin
                scr_ack = 1'b1; scr_rdata = rd;
            end
            @(posedge clk); #1;
        end
        scr_ack = 1'b0; req = 1'b0; we = 1'b0;
        check("scr_req_done", scr_req, 0);
        check("scr_ready_done", ready, 1);
        check("scr_rvalid", rvalid, !w);
        if (!w) check("scr_rdata", rdata, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        scr_ack = 1'b0; scr_rdata = '0; kbd_code = '0; kbd_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_scr_req", scr_req, 0);
        check("rst_scr_we", scr_we, 0);
        check("rst_ovf", kbd_overflow, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;

        // RAM, including the top word
        cpu_write(15'd5, 16'h1234);
        cpu_read(15'd5, 16'h1234);
        cpu_write(15'd16383, 16'hABCD);
        cpu_read(15'd16383, 16'hABCD);
        cpu_write(15'd7, 16'h0777);

        // screen write with 3-cycle ack, RAM write attempted while busy is ignored
        scr_access(1'b1, 15'd16384, 16'hBEEF, 3, 16'h0000, 13'd0, 1'b1);
        cpu_read(15'd7, 16'h0777);
        // screen read at the last screen word
        scr_access(1'b0, 15'd24575, 16'h0000, 1, 16'h5A5A, 13'd8191, 1'b0);

        // keyboard basic
        kbd_push(8'h41);
        kbd_push(8'h42);
        cpu_read(KBD, 16'h0041);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0042);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0000);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0000);

        // overflow
        for (int i = 1; i <= 5; i++) kbd_push(8'(i));
        check("ovf_set", kbd_overflow, 1);
        cpu_read(KBD, 16'h0001);
        cpu_write(KBD, 16'h0000);
        check("ovf_clear", kbd_overflow, 0);
        cpu_read(KBD, 16'h0002);
        kbd_push(8'h06);
        check("ovf_full4", kbd_overflow, 0);

        // push and pop while full, then confirm still full
        kbd_push_pop(8'h07);
        check("ovf_pushpop_full", kbd_overflow, 0);
        kbd_push(8'h08);
        check("ovf_still_full", kbd_overflow, 1);
        cpu_read(KBD, 16'h0003);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0004);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0006);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0007);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0000);

        // push and pop while empty keeps the push
        kbd_push_pop(8'h55);
        cpu_read(KBD, 16'h0055);
        cpu_write(KBD, 16'h0000);
        cpu_read(KBD, 16'h0000);

        // unmapped space
        cpu_read(15'd24577, 16'h0000);
        cpu_write(15'd32767, 16'hFFFF);
        cpu_read(15'd32767, 16'h0000);

        // reset during a screen read, then a stale ack
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 15'd16400;
        @(posedge clk); #1;
        req = 1'b0;
        check("mid_scr_req", scr_req, 1);
        check("mid_scr_addr", scr_addr, 13'd16);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_scr_req", scr_req, 0);
        check("abort_ready", ready, 1);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        rv_snap = rv_count;
        @(posedge clk); #1;
        reset = 1'b1; scr_ack = 1'b1; scr_rdata = 16'hFFFF;
        @(posedge clk); #1;
        scr_ack = 1'b0;
        check("late_ack_scr_req", scr_req, 0);
        check("late_ack_ready", ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("late_ack_no_rvalid", rv_count, rv_snap);
        cpu_read(15'd5, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
